// File: rtl/count_seq_ctrl.sv
// Sequencer for an external 4-bit down-counter: load, run with optional prescaled clock enable, expire.
// Optional prescaler is built when CNT_PRESCALE_EN is defined; otherwise the counter is enabled every RUN cycle.
module count_seq_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] period,
  input  logic [3:0] prescale,
  input  logic       auto_reload,
  input  logic [3:0] cnt_count,
  output logic       cnt_clk_en,
  output logic       cnt_count_en,
  output logic       cnt_ld_en,
  output logic [3:0] cnt_ld,
  output logic       busy,
  output logic       tick,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t     state, state_d;
  logic [3:0] period_q, period_d;
  logic       auto_q, auto_d;
  logic       expire;
  logic       clk_en_d;

`ifdef CNT_PRESCALE_EN
  logic [3:0] prescale_q, prescale_d;
  logic [3:0] presc, presc_d;
`else
  logic       prescale_unused;
  assign prescale_unused = ^prescale;
`endif

  always_comb begin
    state_d  = state;
    period_d = period_q;
    auto_d   = auto_q;
`ifdef CNT_PRESCALE_EN
    prescale_d = prescale_q;
`endif
    expire = (state == RUN) && cnt_clk_en && (cnt_count == '0);

    if (stop) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: if (start) begin
          state_d  = LOAD;
          period_d = period;
          auto_d   = auto_reload;
`ifdef CNT_PRESCALE_EN
          prescale_d = prescale;
`endif
        end
        LOAD:    state_d = RUN;
        RUN:     if (expire) state_d = auto_q ? LOAD : DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // Outputs are registered, so the clock enable is computed from the next prescaler value.
`ifdef CNT_PRESCALE_EN
    presc_d = '0;
    if ((state_d == RUN) && (state == RUN) && !cnt_clk_en)
      presc_d = presc + 4'd1;
    clk_en_d = (state_d == RUN) && (presc_d == prescale_d);
`else
    clk_en_d = (state_d == RUN);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      period_q     <= '0;
      auto_q       <= 1'b0;
      cnt_clk_en   <= 1'b0;
      cnt_count_en <= 1'b0;
      cnt_ld_en    <= 1'b0;
      cnt_ld       <= '0;
      busy         <= 1'b0;
      tick         <= 1'b0;
      done         <= 1'b0;
`ifdef CNT_PRESCALE_EN
      prescale_q   <= '0;
      presc        <= '0;
`endif
    end else begin
      state        <= state_d;
      period_q     <= period_d;
      auto_q       <= auto_d;
      cnt_clk_en   <= clk_en_d;
      cnt_count_en <= (state_d == RUN);
      cnt_ld_en    <= (state_d == LOAD);
      cnt_ld       <= (state_d == LOAD) ? period_d : '0;
      busy         <= (state_d != IDLE);
      tick         <= expire && !stop;
      done         <= (state == DONE) && !stop;
`ifdef CNT_PRESCALE_EN
      prescale_q   <= prescale_d;
      presc        <= presc_d;
`endif
    end
  end

endmodule

// File: doc/count_seq_ctrl.md
COUNT_SEQ_CTRL -- requirements
Module: count_seq_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: start  in  1  launch request, sampled only in IDLE.
REQ-004 SHALL have ports: stop  in  1  abort request, sampled in every state.
REQ-005 SHALL have ports: period  in  4  reload value for the down-counter, latched on accepted start.
REQ-006 SHALL have ports: prescale  in  4  clock-enable divide ratio minus one, latched on accepted start.
REQ-007 SHALL have ports: auto_reload  in  1  1 = restart after expiry, 0 = one-shot; latched on accepted start.
REQ-008 SHALL have ports: cnt_count  in  4  current value returned by the down-counter datapath.
REQ-009 SHALL have ports: cnt_clk_en / cnt_count_en / cnt_ld_en  out  1 each  enables driven to the down-counter.
REQ-010 SHALL have ports: cnt_ld  out  4  load value driven to the down-counter.
REQ-011 SHALL have ports: busy  out  1  state != IDLE; tick  out  1  expiry pulse; done  out  1  one-shot completion pulse.

Function
REQ-012 SHALL implement a Moore FSM with states IDLE, LOAD, RUN, DONE; all outputs registered or decoded from registered state.
REQ-013 SHALL, in IDLE with start=1 and stop=0, latch period/prescale/auto_reload and enter LOAD next edge; start in any other state SHALL be ignored.
REQ-014 SHALL assert cnt_ld_en=1 and cnt_ld=latched period for exactly the one cycle spent in LOAD, then enter RUN.
REQ-015 SHALL hold cnt_count_en=1 throughout RUN and 0 in all other states.
REQ-016 SHALL clear the internal 4-bit prescaler on RUN entry; in RUN, cnt_clk_en=1 when prescaler==latched prescale (prescaler then wraps to 0), else 0; cnt_clk_en=0 outside RUN.
REQ-017 SHALL detect expiry in RUN at the edge where cnt_clk_en=1 and cnt_count==0 (counter underflows to 4'hF on that edge).
REQ-018 SHALL on expiry pulse tick=1 for one cycle and go to LOAD if auto_reload latched =1, else to DONE.
REQ-019 SHALL in DONE pulse done=1 for one cycle and return to IDLE unconditionally.
REQ-020 SHALL yield expiry after (P+1)*(S+1) RUN cycles for period P, prescale S; auto-reload tick spacing (P+1)*(S+1)+1 cycles.
REQ-021 SHALL treat period=0 as valid: expiry on the first cnt_clk_en pulse in RUN.
REQ-022 SHALL give stop priority over start and expiry: stop=1 in any state forces IDLE next edge, no tick, no done.
REQ-023 SHALL with start=1 and stop=1 in IDLE remain in IDLE.

Reset
REQ-024 SHALL, at a rising edge with rst=0, force IDLE, prescaler=0, latched registers=0, and all outputs (cnt_clk_en, cnt_count_en, cnt_ld_en, cnt_ld, busy, tick, done) to 0.
REQ-025 SHALL apply reset mid-operation identically, overriding start, stop and expiry; no tick or done emitted.

Configuration
REQ-026 SHALL honour macro CNT_PRESCALE_EN: defined -> prescaler per REQ-016.
REQ-027 SHALL, with CNT_PRESCALE_EN undefined, omit prescaler logic, ignore prescale, and drive cnt_clk_en=1 throughout RUN (expiry after P+1 RUN cycles).

Verification
REQ-028 SHALL cover one-shot: period=3, prescale=1, auto_reload=0, start -> LOAD 1 cycle, tick after 8 RUN cycles, done next cycle, busy low after.
REQ-029 SHALL cover auto-reload: period=2, prescale=0, auto_reload=1 -> tick every 4 cycles repeatedly, cnt_ld_en pulse with cnt_ld=2 between ticks, done never.
REQ-030 SHALL cover stop mid-RUN: period=9, prescale=2, stop at RUN cycle 5 -> IDLE next edge, no tick, cnt_count_en=0.
REQ-031 SHALL cover period=0, prescale=3 -> tick after 4 RUN cycles.
REQ-032 SHALL cover rst=0 asserted in RUN with start held -> all outputs 0 next edge, IDLE; start and stop together in IDLE -> busy stays 0.
REQ-033 SHALL cover CNT_PRESCALE_EN undefined with prescale=7, period=3 -> tick after 4 RUN cycles.
